// File: rtl/d_ff_pkg.sv
// Shared constants and parameter legality check for the d_ff register cascade.
package d_ff_pkg;

    localparam int D_FF_WIDTH_DEFAULT  = 1;
    localparam int D_FF_STAGES_DEFAULT = 1;
    localparam int D_FF_MAX_WIDTH      = 64;
    localparam int D_FF_MAX_STAGES     = 8;

    // True when the WIDTH/STAGES pair lies inside the supported range.
    function automatic bit d_ff_params_ok(input int width, input int stages);
        return (width >= 1) && (width <= D_FF_MAX_WIDTH) &&
               (stages >= 1) && (stages <= D_FF_MAX_STAGES);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register of the d_ff cascade: synchronous active-low reset to
// RESET_VALUE. With D_FF_SCAN_EN defined, a scan mux selects a one-bit left
// shift (scan input into bit 0) instead of the parallel data input.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = D_FF_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef D_FF_SCAN_EN
    input  logic             se_i,
    input  logic             si_i,
`endif
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    // Next-state select: parallel capture, or serial shift when scanning.
    always_comb begin
        stage_d = d_i;
`ifdef D_FF_SCAN_EN
        if (se_i) begin
            stage_d = (stage_q << 1) | WIDTH'(si_i);
        end
`endif
    end

    // State register; reset wins over both capture and scan shift.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q <= RESET_VALUE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/d_ff.sv
// Parameterised D flip-flop cascade: STAGES registers of WIDTH bits between
// D and Q, synchronous active-low reset RST, QN = ~Q.
// Optional macro D_FF_SCAN_EN adds SE/SI/SO: the stages form one serial scan
// chain running from SI into bit 0 of stage 0 out of the MSB of the last stage.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = D_FF_WIDTH_DEFAULT,
    parameter int               STAGES      = D_FF_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef D_FF_SCAN_EN
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    // Reject unsupported geometries while elaborating.
    if (!d_ff_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("d_ff: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic [WIDTH-1:0] stage_in [STAGES];
    logic [WIDTH-1:0] stage_out[STAGES];
`ifdef D_FF_SCAN_EN
    logic             scan_in  [STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage 0 is fed from the ports; later stages from their predecessor.
        if (k == 0) begin : g_head
            assign stage_in[k] = D;
`ifdef D_FF_SCAN_EN
            assign scan_in[k]  = SI;
`endif
        end else begin : g_link
            assign stage_in[k] = stage_out[k-1];
`ifdef D_FF_SCAN_EN
            assign scan_in[k]  = stage_out[k-1][WIDTH-1];
`endif
        end

        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk_i  (CLK),
            .rst_ni (RST),
`ifdef D_FF_SCAN_EN
            .se_i   (SE),
            .si_i   (scan_in[k]),
`endif
            .d_i    (stage_in[k]),
            .q_o    (stage_out[k])
        );
    end

    // Outputs come straight from the last register; QN is its complement.
    assign Q  = stage_out[STAGES-1];
    assign QN = ~stage_out[STAGES-1];
`ifdef D_FF_SCAN_EN
    assign SO = stage_out[STAGES-1][WIDTH-1];
`endif

endmodule

// File: tb/tb_d_ff.sv
// Scoreboard bench for d_ff: the driver applies directed vectors on the
// falling edge and queues the hand-computed Q expected after the next rising
// edge; a monitor pops and compares Q/QN (and SO with D_FF_SCAN_EN) 1 ns after
// each rising edge.
module tb_d_ff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters (plain D flip-flop).
    logic       a_rst, a_d;
    logic       a_q, a_qn;
    // Instance B: WIDTH=8, STAGES=3, reset to 0x00.
    // Instance C: WIDTH=8, STAGES=3, reset to 0x3C; shares B's inputs.
    logic       bc_rst;
    logic [7:0] bc_d;
    logic [7:0] b_q, b_qn, c_q, c_qn;

`ifdef D_FF_SCAN_EN
    logic       a_se, a_si, a_so;
    logic       b_se, b_si, b_so;
    logic       c_se, c_si, c_so;
    // Instance S: WIDTH=4, STAGES=2 scan chain.
    logic       s_rst, s_se, s_si, s_so;
    logic [3:0] s_d, s_q, s_qn;
`endif

    d_ff dut_a (
        .CLK (clk), .RST (a_rst),
`ifdef D_FF_SCAN_EN
        .SE (a_se), .SI (a_si), .SO (a_so),
`endif
        .D (a_d), .Q (a_q), .QN (a_qn)
    );

    d_ff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) dut_b (
        .CLK (clk), .RST (bc_rst),
`ifdef D_FF_SCAN_EN
        .SE (b_se), .SI (b_si), .SO (b_so),
`endif
        .D (bc_d), .Q (b_q), .QN (b_qn)
    );

    d_ff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h3C)) dut_c (
        .CLK (clk), .RST (bc_rst),
`ifdef D_FF_SCAN_EN
        .SE (c_se), .SI (c_si), .SO (c_so),
`endif
        .D (bc_d), .Q (c_q), .QN (c_qn)
    );

`ifdef D_FF_SCAN_EN
    d_ff #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'h0)) dut_s (
        .CLK (clk), .RST (s_rst), .SE (s_se), .SI (s_si), .SO (s_so),
        .D (s_d), .Q (s_q), .QN (s_qn)
    );
    logic exp_s_q[$];
`endif

    logic       exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] exp_c_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one queued expectation is consumed per rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_a_q.size() > 0) begin
            logic ea;
            ea = exp_a_q.pop_front();
            check("a_q",  {7'd0, a_q},  {7'd0, ea});
            check("a_qn", {7'd0, a_qn}, {7'd0, ~ea});
        end
        if (exp_b_q.size() > 0) begin
            logic [7:0] eb;
            eb = exp_b_q.pop_front();
            check("b_q",  b_q,  eb);
            check("b_qn", b_qn, ~eb);
        end
        if (exp_c_q.size() > 0) begin
            logic [7:0] ec;
            ec = exp_c_q.pop_front();
            check("c_q",  c_q,  ec);
            check("c_qn", c_qn, ~ec);
        end
`ifdef D_FF_SCAN_EN
        if (exp_s_q.size() > 0) begin
            logic es;
            es = exp_s_q.pop_front();
            check("s_so", {7'd0, s_so}, {7'd0, es});
        end
`endif
    end

    typedef struct packed {
        logic rst;
        logic d;
        logic glitch;
        logic exp_q;
    } va_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] d;
        logic [7:0] exp_b;
        logic [7:0] exp_c;
    } vbc_t;

    typedef struct packed {
        logic rst;
        logic se;
        logic si;
        logic exp_so;
    } vs_t;

    va_t va [10] = '{
        '{1'b0, 1'b1, 1'b0, 1'b0},   // reset overrides capture of D=1
        '{1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 1'b1, 1'b0},   // D pulses between edges only
        '{1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b0, 1'b1, 1'b0, 1'b0}    // reset again with D=1
    };

    vbc_t vbc [15] = '{
        '{1'b0, 8'h00, 8'h00, 8'h3C},
        '{1'b1, 8'hA5, 8'h00, 8'h3C},
        '{1'b1, 8'h00, 8'h00, 8'h3C},
        '{1'b1, 8'h00, 8'hA5, 8'hA5},  // A5 emerges three edges after capture
        '{1'b1, 8'h00, 8'h00, 8'h00},
        '{1'b1, 8'h11, 8'h00, 8'h00},
        '{1'b1, 8'h22, 8'h00, 8'h00},
        '{1'b1, 8'h33, 8'h11, 8'h11},
        '{1'b0, 8'h44, 8'h00, 8'h3C},  // reset with 22/33 in flight
        '{1'b1, 8'h55, 8'h00, 8'h3C},
        '{1'b1, 8'h66, 8'h00, 8'h3C},
        '{1'b1, 8'h77, 8'h55, 8'h55},
        '{1'b1, 8'h77, 8'h66, 8'h66},
        '{1'b1, 8'h77, 8'h77, 8'h77},
        '{1'b1, 8'h77, 8'h77, 8'h77}
    };

    vs_t vs [11] = '{
        '{1'b0, 1'b1, 1'b1, 1'b0},     // reset overrides scan shift
        '{1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1},     // first shifted bit reaches SO
        '{1'b1, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        a_rst  = 1'b0;
        a_d    = 1'b0;
        bc_rst = 1'b0;
        bc_d   = 8'h00;
`ifdef D_FF_SCAN_EN
        a_se = 1'b0; a_si = 1'b0;
        b_se = 1'b0; b_si = 1'b0;
        c_se = 1'b0; c_si = 1'b0;
        s_rst = 1'b0; s_se = 1'b0; s_si = 1'b0; s_d = 4'h0;
`endif

        // Plain flip-flop: reset, toggling data, between-edge pulse.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_rst = va[i].rst;
            a_d   = va[i].d;
            exp_a_q.push_back(va[i].exp_q);
            if (va[i].glitch) begin
                #2 a_d = 1'b1;
                #2 a_d = 1'b0;
            end
        end

        // Three-stage cascades: latency, reset mid-pipeline, hold.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bc_rst = vbc[i].rst;
            bc_d   = vbc[i].d;
            exp_b_q.push_back(vbc[i].exp_b);
            exp_c_q.push_back(vbc[i].exp_c);
        end

`ifdef D_FF_SCAN_EN
        // Scan chain: eight-bit serial path from SI to SO.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            s_rst = vs[i].rst;
            s_se  = vs[i].se;
            s_si  = vs[i].si;
            exp_s_q.push_back(vs[i].exp_so);
        end
`endif

        // Allow the last expectations to drain, bounded to a few edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        total++;
        if (exp_a_q.size() + exp_b_q.size() + exp_c_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     exp_a_q.size() + exp_b_q.size() + exp_c_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
